// File: rtl/uart_tx_framed.sv
// uart_tx_framed: framed UART transmitter (start, DATA_BITS payload LSB first,
// optional parity, one or two stop bits). Frame settings are captured when a
// request is accepted in IDLE, so later input changes do not disturb the frame.
//
// Optional feature: define UART_TX_PARITY_EN to add the PARITY state and the
// i_parity_en / i_parity_odd ports. Without it no parity logic exists.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit period (2..65535)
//   DATA_BITS     payload bits per frame (5..9)
// Ports:
//   i_clk         clock, all state updates on rising edge
//   i_rst         synchronous active-high reset
//   i_start       request one frame (honoured in IDLE only)
//   i_data        payload
//   i_two_stop    1: two stop bits, 0: one stop bit
//   i_parity_en   1: append parity bit          (UART_TX_PARITY_EN only)
//   i_parity_odd  1: odd parity, 0: even parity (UART_TX_PARITY_EN only)
//   o_busy        frame in progress (START..STOP)
//   o_done        one-cycle pulse when a frame completes
//   o_dout        serial line, idle high
module uart_tx_framed #(
    parameter int unsigned CLKS_PER_BIT = 243,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_two_stop,
`ifdef UART_TX_PARITY_EN
    input  logic                 i_parity_en,
    input  logic                 i_parity_odd,
`endif
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_dout
);

    localparam int unsigned TICK_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP,
        DONE
    } state_t;

    state_t               state;
    logic [TICK_W-1:0]    tick;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] data_q;
    logic                 two_stop_q;
`ifdef UART_TX_PARITY_EN
    logic                 parity_en_q;
    logic                 parity_bit_q;
`endif

    logic tick_last;
    assign tick_last = (tick == TICK_LAST);

    // Frame sequencer; outputs are loaded together with the state they belong to.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            tick         <= '0;
            bit_cnt      <= '0;
            data_q       <= '0;
            two_stop_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_en_q  <= 1'b0;
            parity_bit_q <= 1'b0;
`endif
            o_dout       <= 1'b1;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    o_dout <= 1'b1;
                    o_busy <= 1'b0;
                    tick   <= '0;
                    if (i_start) begin
                        data_q       <= i_data;
                        two_stop_q   <= i_two_stop;
`ifdef UART_TX_PARITY_EN
                        parity_en_q  <= i_parity_en;
                        // Parity bit is fixed at acceptance: even = XOR of data, odd = inverse.
                        parity_bit_q <= (^i_data) ^ i_parity_odd;
`endif
                        bit_cnt      <= '0;
                        state        <= START;
                        o_dout       <= 1'b0;
                        o_busy       <= 1'b1;
                    end
                end
                START: begin
                    if (tick_last) begin
                        tick    <= '0;
                        bit_cnt <= '0;
                        state   <= DATA;
                        o_dout  <= data_q[0];
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
                DATA: begin
                    if (tick_last) begin
                        tick <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            if (parity_en_q) begin
                                state  <= PARITY;
                                o_dout <= parity_bit_q;
                            end else begin
                                state  <= STOP;
                                o_dout <= 1'b1;
                            end
`else
                            state  <= STOP;
                            o_dout <= 1'b1;
`endif
                        end else begin
                            // Shift so the next payload bit is always at index 0.
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            data_q  <= {1'b0, data_q[DATA_BITS-1:1]};
                            o_dout  <= data_q[1];
                        end
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick_last) begin
                        tick   <= '0;
                        state  <= STOP;
                        o_dout <= 1'b1;
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (tick_last) begin
                        tick <= '0;
                        // bit_cnt is reused to count the second stop bit.
                        if (two_stop_q && (bit_cnt == '0)) begin
                            bit_cnt <= BIT_W'(1);
                        end else begin
                            bit_cnt <= '0;
                            state   <= DONE;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                        end
                        o_dout <= 1'b1;
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_dout <= 1'b1;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    tick   <= '0;
                    o_dout <= 1'b1;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Testbench for uart_tx_framed: directed frames on an 8-bit and a 5-bit
// instance (CLKS_PER_BIT=4). Each request pushes its expected line waveform
// into a queue; a monitor pops it when the selected DUT raises o_busy and
// checks every cycle of the frame, the o_done cycle and the idle line.
module tb_uart_tx_framed;

    localparam int unsigned CPB = 4;

    typedef struct {
        logic [15:0] bits;       // bit i = line level during bit period i
        int          len;        // bit periods in frame
        int          start_cyc;  // cycle in which o_busy must first be seen
        int          abort_pos;  // cycle offset of expected abort, -1 if none
        string       name;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0;
    logic       start5 = 1'b0;
    logic [7:0] data8 = '0;
    logic [4:0] data5 = '0;
    logic       two_stop = 1'b0;
`ifdef UART_TX_PARITY_EN
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
`endif
    logic       busy8, done8, dout8;
    logic       busy5, done5, dout5;
    logic       sel5 = 1'b0;
    logic       m_busy, m_done, m_dout;

    int     cyc = 0;
    int     n_cmp = 0;
    int     n_err = 0;
    bit     mon_en = 1'b0;
    bit     mon_active = 1'b0;
    frame_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut8 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start8),
        .i_data      (data8),
        .i_two_stop  (two_stop),
`ifdef UART_TX_PARITY_EN
        .i_parity_en (parity_en),
        .i_parity_odd(parity_odd),
`endif
        .o_busy      (busy8),
        .o_done      (done8),
        .o_dout      (dout8)
    );

    uart_tx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(5)) dut5 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start5),
        .i_data      (data5),
        .i_two_stop  (two_stop),
`ifdef UART_TX_PARITY_EN
        .i_parity_en (parity_en),
        .i_parity_odd(parity_odd),
`endif
        .o_busy      (busy5),
        .o_done      (done5),
        .o_dout      (dout5)
    );

    assign m_busy = sel5 ? busy5 : busy8;
    assign m_done = sel5 ? done5 : done8;
    assign m_dout = sel5 ? dout5 : dout8;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: follows the selected DUT, one expected frame per o_busy rise.
    initial begin : monitor
        frame_t cur;
        int     pos;
        pos = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (!mon_active && m_busy) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame_busy", 32'(m_busy), 32'd0);
                    end else begin
                        cur = exp_q.pop_front();
                        mon_active = 1'b1;
                        pos = 0;
                        check({cur.name, "_start_cycle"}, 32'(cyc), 32'(cur.start_cyc));
                    end
                end
                if (mon_active) begin
                    if (cur.abort_pos >= 0 && pos == cur.abort_pos) begin
                        check({cur.name, "_abort_done_busy_dout"},
                              {29'd0, m_done, m_busy, m_dout}, 32'b001);
                        mon_active = 1'b0;
                    end else if (pos < cur.len * int'(CPB)) begin
                        check($sformatf("%s_period%0d_done_busy_dout", cur.name, pos / int'(CPB)),
                              {29'd0, m_done, m_busy, m_dout},
                              {29'd0, 1'b0, 1'b1, cur.bits[pos / int'(CPB)]});
                    end else begin
                        check({cur.name, "_done_cycle_done_busy_dout"},
                              {29'd0, m_done, m_busy, m_dout}, 32'b101);
                        mon_active = 1'b0;
                    end
                    pos++;
                end else if (!m_busy) begin
                    check("idle_done_busy_dout", {29'd0, m_done, m_busy, m_dout}, 32'b001);
                end
            end
        end
    end

    // One-cycle request; afterwards the inputs are scrambled to prove they were latched.
    task automatic send(input logic [8:0] data, input bit two, input logic [15:0] bits,
                        input int len, input string name);
        frame_t f;
        @(negedge clk);
        f.bits = bits;
        f.len = len;
        f.start_cyc = cyc + 1;
        f.abort_pos = -1;
        f.name = name;
        exp_q.push_back(f);
        two_stop = two;
        if (sel5) begin
            start5 = 1'b1;
            data5 = data[4:0];
        end else begin
            start8 = 1'b1;
            data8 = data[7:0];
        end
        @(negedge clk);
        start5 = 1'b0;
        start8 = 1'b0;
        data8 = ~data8;
        data5 = ~data5;
        two_stop = ~two_stop;
`ifdef UART_TX_PARITY_EN
        parity_en = ~parity_en;
        parity_odd = ~parity_odd;
`endif
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_active) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_completed_in_time"}, 32'(n < 300), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        frame_t f;
        int     acc;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // 8-bit instance, one and two stop bits, assorted payloads
        send(9'h0A5, 1'b0, 16'(10'b1_10100101_0), 10, "a5_8n1");
        wait_idle("a5_8n1");
        send(9'h0A5, 1'b1, 16'(11'b11_10100101_0), 11, "a5_8n2");
        wait_idle("a5_8n2");
        send(9'h000, 1'b0, 16'(10'b1_00000000_0), 10, "00_8n1");
        wait_idle("00_8n1");
        send(9'h0FF, 1'b1, 16'(11'b11_11111111_0), 11, "ff_8n2");
        wait_idle("ff_8n2");

`ifdef UART_TX_PARITY_EN
        parity_en = 1'b1;
        parity_odd = 1'b0;
        send(9'h0A5, 1'b0, 16'(11'b1_0_10100101_0), 11, "a5_8e1");
        wait_idle("a5_8e1");
        parity_en = 1'b1;
        parity_odd = 1'b1;
        send(9'h0A5, 1'b0, 16'(11'b1_1_10100101_0), 11, "a5_8o1");
        wait_idle("a5_8o1");
        parity_en = 1'b1;
        parity_odd = 1'b0;
        send(9'h0A5, 1'b1, 16'(12'b11_0_10100101_0), 12, "a5_8e2");
        wait_idle("a5_8e2");
        parity_en = 1'b0;
        parity_odd = 1'b0;
`endif

        // 0x3C with start pulses in cycles 10 and 41 and data changed mid-frame
        @(negedge clk);
        acc = cyc;
        f.bits = 16'(10'b1_00111100_0);
        f.len = 10;
        f.start_cyc = acc + 1;
        f.abort_pos = -1;
        f.name = "3c_restart_ignored";
        exp_q.push_back(f);
        two_stop = 1'b0;
        data8 = 8'h3C;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        data8 = 8'hFF;
        two_stop = 1'b1;
        repeat (5) @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (30) @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        two_stop = 1'b0;
        wait_idle("3c_restart_ignored");

        // Reset during DATA bit 3 aborts the frame without o_done
        @(negedge clk);
        acc = cyc;
        f.bits = 16'(10'b1_00000000_0);
        f.len = 10;
        f.start_cyc = acc + 1;
        f.abort_pos = 18;
        f.name = "reset_abort";
        exp_q.push_back(f);
        data8 = 8'h00;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_idle("reset_abort");
        repeat (10) @(negedge clk);

        // Reset and start together: no frame may start
        rst = 1'b1;
        start8 = 1'b1;
        data8 = 8'h81;
        @(negedge clk);
        rst = 1'b0;
        start8 = 1'b0;
        repeat (8) @(negedge clk);

        // Back-to-back with i_start held: accepts in cycles 0 and 42
        @(negedge clk);
        acc = cyc;
        f.bits = 16'(10'b1_01010101_0);
        f.len = 10;
        f.abort_pos = -1;
        f.start_cyc = acc + 1;
        f.name = "55_b2b_first";
        exp_q.push_back(f);
        f.start_cyc = acc + 43;
        f.name = "55_b2b_second";
        exp_q.push_back(f);
        data8 = 8'h55;
        two_stop = 1'b0;
        start8 = 1'b1;
        repeat (43) @(negedge clk);
        start8 = 1'b0;
        wait_idle("55_b2b");

        // 5-bit instance
        sel5 = 1'b1;
        send(9'h01F, 1'b0, 16'(7'b1_11111_0), 7, "1f_5n1");
        wait_idle("1f_5n1");
        send(9'h00A, 1'b0, 16'(7'b1_01010_0), 7, "0a_5n1");
        wait_idle("0a_5n1");
        send(9'h00A, 1'b1, 16'(8'b11_01010_0), 8, "0a_5n2");
        wait_idle("0a_5n2");
        sel5 = 1'b0;

        repeat (5) @(negedge clk);
        check("expected_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_framed.md
UART_TX_FRAMED -- requirements
Module: uart_tx_framed

Interface
REQ-001 Parameter CLKS_PER_BIT, default 243, meaning clock cycles per serial bit period, legal range 2..65535.
REQ-002 Parameter DATA_BITS, default 8, meaning payload bits per frame, legal range 5..9.
REQ-003 Port i_clk  input  1  meaning sole clock; all state updates on its rising edge.
REQ-004 Port i_rst  input  1  meaning reset, synchronous and active-high.
REQ-005 Port i_start  input  1  meaning request to transmit one frame.
REQ-006 Port i_data  input  DATA_BITS  meaning payload, transmitted LSB first.
REQ-007 Port i_two_stop  input  1  meaning 1 selects two stop bits, 0 selects one stop bit.
REQ-008 Port i_parity_en  input  1  meaning 1 appends a parity bit (only when UART_TX_PARITY_EN is defined).
REQ-009 Port i_parity_odd  input  1  meaning 1 selects odd parity, 0 selects even parity (only when UART_TX_PARITY_EN is defined).
REQ-010 Port o_busy  output  1  meaning frame in progress.
REQ-011 Port o_done  output  1  meaning one-cycle pulse on frame completion.
REQ-012 Port o_dout  output  1  meaning serial line, idle high.

Function
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, DONE; no other reachable state.
REQ-014 A request SHALL be accepted only in IDLE with i_start=1 (cycle 0); i_data, i_two_stop, i_parity_en, i_parity_odd SHALL be latched in that cycle and the FSM SHALL enter START at cycle 1.
REQ-015 i_start SHALL be ignored in every state other than IDLE; input changes after acceptance SHALL NOT affect the frame.
REQ-016 Each of START, each DATA bit, PARITY and each STOP bit SHALL drive o_dout for exactly CLKS_PER_BIT cycles, timed by a tick counter of width $clog2(CLKS_PER_BIT) that wraps from CLKS_PER_BIT-1 to 0.
REQ-017 START SHALL drive o_dout=0; DATA SHALL drive latched bits 0..DATA_BITS-1 in order via a bit counter that leaves DATA after bit DATA_BITS-1.
REQ-018 After DATA, the FSM SHALL go to PARITY if the latched parity enable is 1, else to STOP.
REQ-019 PARITY SHALL drive XOR of all latched data bits for even, its inverse for odd.
REQ-020 STOP SHALL drive o_dout=1 for one or two bit periods per latched i_two_stop, then enter DONE.
REQ-021 DONE SHALL last exactly one cycle with o_done=1, o_busy=0, o_dout=1, then enter IDLE; i_start in DONE SHALL be ignored.
REQ-022 o_busy SHALL be 1 in START, DATA, PARITY, STOP and 0 in IDLE and DONE; o_dout SHALL be 1 in IDLE.
REQ-023 Frame length SHALL be N=1+DATA_BITS+P+S bit periods (P in {0,1}, S in {1,2}); o_done SHALL assert at cycle 1+N*CLKS_PER_BIT after acceptance; the earliest next acceptance SHALL be cycle 2+N*CLKS_PER_BIT.
REQ-024 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-025 i_rst=1 at a rising edge SHALL force IDLE, clear tick and bit counters and latched data, and set o_dout=1, o_busy=0, o_done=0 from the next cycle.
REQ-026 Reset mid-frame SHALL abort the frame with no o_done pulse; i_rst SHALL take priority over a simultaneous i_start.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: PARITY state, i_parity_en and i_parity_odd SHALL exist and behave per REQ-018/REQ-019.
REQ-028 Macro UART_TX_PARITY_EN undefined: i_parity_en and i_parity_odd SHALL be absent, PARITY state and parity logic SHALL not be synthesised, P=0 always.

Verification
REQ-029 CLKS_PER_BIT=4, DATA_BITS=8, one stop, no parity, send 0xA5 -> o_dout bit sequence 0,1,0,1,0,0,1,0,1,1, 4 cycles each, o_done pulse at cycle 41, o_busy high cycles 1..40.
REQ-030 Same settings, parity defined, even parity, 0xA5 -> parity bit 0; odd parity -> parity bit 1; two stop bits -> o_done at cycle 49.
REQ-031 DATA_BITS=5, send 0x1F with one stop bit -> o_dout sequence 0,1,1,1,1,1,1, o_done at cycle 29; upper bits of i_data irrelevant.
REQ-032 i_start pulsed at cycles 10 and 41 during a 0x3C frame, i_data changed mid-frame -> frame unchanged, no second frame, o_done single pulse.
REQ-033 i_rst asserted during DATA bit 3 -> o_dout=1, o_busy=0 next cycle, no o_done; i_start and i_rst together -> stays IDLE.
REQ-034 Back-to-back: i_start held high continuously with 0x55 -> frames start at cycles 0 and 42 (CLKS_PER_BIT=4, 10-bit frame), one o_done per frame.
